// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC generation, 1-cycle imem requests, prefetch FIFO
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          push;
    logic          pop;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    // An in-flight request already owns a FIFO slot, so it counts against the credit.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = rst ? RESET_PC : fetch_pc;

    assign push       = inflight && !redirect;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect;

    assign inst    = inst_valid ? inst_mem[rd_ptr] : 32'h0;
    assign inst_pc = inst_valid ? pc_mem[rd_ptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomised checks for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int total = 0;
    int passed = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous read, word = 0x1000_0000 | address.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (32'h1000_0000 | imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        total++;
        if ({imem_req, imem_addr, inst_valid, inst, inst_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0})
            $display("FAIL reset_state: got req=%b addr=%h v=%b inst=%h pc=%h required 0/0/0/0/0",
                     imem_req, imem_addr, inst_valid, inst, inst_pc);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL reset_first_req: got req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        inst_ready = 1'b1;
        step();
        total++;
        if (inst_valid !== 1'b0)
            $display("FAIL stream_cycle1_valid: got %b required 0", inst_valid);
        else passed++;
        step();
        for (int k = 0; k < 8; k++) begin
            exp = 32'(4 * k);
            total++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, exp, 32'h1000_0000 | exp})
                $display("FAIL stream_head%0d: got v=%b pc=%h inst=%h required 1/%h/%h",
                         k, inst_valid, inst_pc, inst, exp, 32'h1000_0000 | exp);
            else passed++;
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seen[$];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (imem_req) seen.push_back(imem_addr);
            step();
        end
        total++;
        if (seen.size() !== 4)
            $display("FAIL bp_req_count: got %0d required 4", seen.size());
        else passed++;
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            total++;
            if (seen[i] !== 32'(4 * i))
                $display("FAIL bp_req_addr%0d: got %h required %h", i, seen[i], 32'(4 * i));
            else passed++;
        end
        total++;
        if ({imem_req, inst_valid, inst_pc, inst} !== {1'b0, 1'b1, 32'h0, 32'h1000_0000})
            $display("FAIL bp_full_hold: got req=%b v=%b pc=%h inst=%h required 0/1/0/10000000",
                     imem_req, inst_valid, inst_pc, inst);
        else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, inst_pc} !== {1'b1, 32'h10, 32'h4})
            $display("FAIL bp_after_pop: got req=%b addr=%h pc=%h required 1/10/4", imem_req, imem_addr, inst_pc);
        else passed++;
        step();
        total++;
        if (imem_req !== 1'b0)
            $display("FAIL bp_refull: got req=%b required 0", imem_req);
        else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        #1;
        total++;
        if (imem_req !== 1'b0)
            $display("FAIL redir_req_in_r: got %b required 0", imem_req);
        else passed++;
        step();
        redirect = 1'b0;
        #1;
        total++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL redir_r1: got v=%b req=%b addr=%h required 0/1/200", inst_valid, imem_req, imem_addr);
        else passed++;
        inst_ready = 1'b1;
        step();
        total++;
        if (inst_valid !== 1'b0)
            $display("FAIL redir_r2_valid: got %b required 0", inst_valid);
        else passed++;
        step();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 32'(32'h200 + 4 * k), 32'(32'h1000_0200 + 4 * k)})
                $display("FAIL redir_head%0d: got v=%b pc=%h inst=%h required 1/%h/%h", k, inst_valid,
                         inst_pc, inst, 32'(32'h200 + 4 * k), 32'(32'h1000_0200 + 4 * k));
            else passed++;
            step();
        end
    endtask

    task automatic test_redirect_hold();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        #1;
        total++;
        if (imem_req !== 1'b0)
            $display("FAIL hold_req_c0: got %b required 0", imem_req);
        else passed++;
        step();
        redirect_pc = 32'h400;
        #1;
        total++;
        if ({imem_req, inst_valid} !== 2'b00)
            $display("FAIL hold_req_c1: got req=%b v=%b required 0/0", imem_req, inst_valid);
        else passed++;
        step();
        redirect = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h400})
            $display("FAIL hold_restart: got req=%b addr=%h required 1/400", imem_req, imem_addr);
        else passed++;
        step();
        step();
        total++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h400})
            $display("FAIL hold_head: got v=%b pc=%h required 1/400", inst_valid, inst_pc);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            exp = 32'hFFFF_FFF8 + 32'(4 * k);
            total++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, exp, 32'h1000_0000 | exp})
                $display("FAIL wrap_head%0d: got v=%b pc=%h inst=%h required 1/%h/%h",
                         k, inst_valid, inst_pc, inst, exp, 32'h1000_0000 | exp);
            else passed++;
            step();
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        logic        stalled;
        int          pops;
        do_reset();
        exp_pc = 32'h0;
        stalled = 1'b0;
        prev_inst = 32'h0;
        prev_pc = 32'h0;
        pops = 0;
        for (int c = 0; c < 2000; c++) begin
            inst_ready = 1'($urandom_range(0, 1));
            redirect = ($urandom_range(0, 31) == 0);
            redirect_pc = $urandom();
            #1;
            if (redirect) begin
                total++;
                if (imem_req !== 1'b0)
                    $display("FAIL rand_req_on_redirect c%0d: got %b required 0", c, imem_req);
                else passed++;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (stalled) begin
                    total++;
                    if ({inst_valid, inst_pc, inst} !== {1'b1, prev_pc, prev_inst})
                        $display("FAIL rand_stall_stable c%0d: got v=%b pc=%h inst=%h required 1/%h/%h",
                                 c, inst_valid, inst_pc, inst, prev_pc, prev_inst);
                    else passed++;
                end
                if (inst_valid && inst_ready) begin
                    total++;
                    if ({inst_pc, inst} !== {exp_pc, 32'h1000_0000 | exp_pc})
                        $display("FAIL rand_pop c%0d: got pc=%h inst=%h required %h/%h",
                                 c, inst_pc, inst, exp_pc, 32'h1000_0000 | exp_pc);
                    else passed++;
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
            stalled = !redirect && inst_valid && !inst_ready;
            prev_pc = inst_pc;
            prev_inst = inst;
            step();
        end
        redirect = 1'b0;
        inst_ready = 1'b0;
        total++;
        if (pops < 500)
            $display("FAIL rand_throughput: got %0d pops required at least 500", pops);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        total++;
        if ({imem_req, inst_valid} !== 2'b01)
            $display("FAIL rmid_full: got req=%b v=%b required 0/1", imem_req, inst_valid);
        else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10})
            $display("FAIL rmid_refetch: got req=%b addr=%h required 1/10", imem_req, imem_addr);
        else passed++;
        step();
        rst = 1'b1;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0})
            $display("FAIL rmid_in_rst: got req=%b addr=%h required 0/0", imem_req, imem_addr);
        else passed++;
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL rmid_after_rst: got v=%b req=%b addr=%h required 0/1/0", inst_valid, imem_req, imem_addr);
        else passed++;
        inst_ready = 1'b1;
        step();
        total++;
        if (inst_valid !== 1'b0)
            $display("FAIL rmid_c1_valid: got %b required 0", inst_valid);
        else passed++;
        step();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({inst_valid, inst_pc} !== {1'b1, 32'(4 * k)})
                $display("FAIL rmid_head%0d: got v=%b pc=%h required 1/%h", k, inst_valid, inst_pc, 32'(4 * k));
            else passed++;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_hold();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
